// File: rtl/mpu_collector_if.sv
// mpu_collector_if: start/element/write-back bundle between the FMA array, collector and register file
interface mpu_collector_if #(
  parameter int FP = 32,
  parameter int M = 3,
  parameter int N = 3,
  parameter int MATRIX_REGISTERS = 8
);
  localparam int MBITS = $clog2(M);
  localparam int NBITS = $clog2(N);
  localparam int AW = $clog2(MATRIX_REGISTERS) + 1;
  logic start_in;
  logic [AW-1:0] dest_addr_in;
  logic [MBITS:0] m_in;
  logic [NBITS:0] n_in;
  logic fma_valid_in;
  logic [FP-1:0] fma_result_in;
  logic [MBITS:0] fma_row_in;
  logic [NBITS:0] fma_col_in;
  logic busy_out;
  logic reg_write_en_out;
  logic [AW-1:0] reg_write_addr_out;
  logic [MBITS:0] reg_write_m_out;
  logic [NBITS:0] reg_write_n_out;
  logic [M*N*FP-1:0] reg_write_matrix_out;
  logic done_out;
  logic error_out;
  modport master (
    output start_in, dest_addr_in, m_in, n_in, fma_valid_in, fma_result_in, fma_row_in, fma_col_in,
    input busy_out, reg_write_en_out, reg_write_addr_out, reg_write_m_out, reg_write_n_out,
    input reg_write_matrix_out, done_out, error_out
  );
  modport slave (
    input start_in, dest_addr_in, m_in, n_in, fma_valid_in, fma_result_in, fma_row_in, fma_col_in,
    output busy_out, reg_write_en_out, reg_write_addr_out, reg_write_m_out, reg_write_n_out,
    output reg_write_matrix_out, done_out, error_out
  );
endinterface

// File: rtl/mpu_collector.sv
// mpu_collector: gathers row/col-tagged FMA results into an MxN buffer and issues one whole-matrix write
module mpu_collector #(
  parameter int FP = 32,
  parameter int M = 3,
  parameter int N = 3,
  parameter int MATRIX_REGISTERS = 8
) (
  input logic clk,
  input logic rst,
  mpu_collector_if.slave bus
);
  localparam int MBITS = $clog2(M);
  localparam int NBITS = $clog2(N);
  localparam int AW = $clog2(MATRIX_REGISTERS) + 1;
  localparam int E = M * N;
  localparam int IW = (E > 1) ? $clog2(E) : 1;
  localparam int CW = $clog2(E + 1);
  localparam int TW = MBITS + NBITS + 2;
  typedef enum logic {COLLECTOR_IDLE, COLLECTOR_WRITE} collector_state_e;
  collector_state_e r_state, w_nstate;
  logic [AW-1:0] r_addr, r_oaddr;
  logic [MBITS:0] r_m, r_om;
  logic [NBITS:0] r_n, r_on;
  logic [FP-1:0] r_buf [E];
  logic [FP-1:0] w_buf [E];
  logic [E-1:0] r_mask;
  logic [CW-1:0] r_cnt;
  logic [E*FP-1:0] r_omat, w_pack;
  logic [TW-1:0] w_tot;
  logic [IW-1:0] w_idx;
  logic r_we, r_err;
  logic w_start, w_legal, w_start_ok, w_start_bad, w_hit, w_fit, w_acc, w_rej, w_fin;
  assign w_idx = IW'(int'(bus.fma_row_in) * N + int'(bus.fma_col_in));
  assign w_start = r_state == COLLECTOR_IDLE && bus.start_in;
  assign w_legal = bus.m_in != '0 && bus.n_in != '0 &&
                   bus.m_in <= (MBITS+1)'(M) && bus.n_in <= (NBITS+1)'(N);
  assign w_start_ok = w_start && w_legal;
  assign w_start_bad = w_start && !w_legal;
  assign w_hit = r_state == COLLECTOR_WRITE && bus.fma_valid_in;
  assign w_fit = bus.fma_row_in < r_m && bus.fma_col_in < r_n && !r_mask[w_idx];
  assign w_acc = w_hit && w_fit;
  assign w_rej = w_hit && !w_fit;
  assign w_tot = TW'(r_m) * TW'(r_n);
  // the element arriving this cycle is folded in so the final write carries it
  assign w_fin = w_acc && TW'(r_cnt + 1'b1) == w_tot;
  always_comb begin
    w_nstate = w_start_ok ? COLLECTOR_WRITE : w_fin ? COLLECTOR_IDLE : r_state;
  end
  always_comb begin
    w_buf = r_buf;
    if (w_acc) w_buf[w_idx] = bus.fma_result_in;
  end
  for (genvar g = 0; g < E; g++) begin : g_pack
    assign w_pack[(E-1-g)*FP +: FP] = w_buf[g];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECTOR_IDLE;
      r_addr <= '0;
      r_m <= '0;
      r_n <= '0;
      r_buf <= '{default: '0};
      r_mask <= '0;
      r_cnt <= '0;
      r_we <= 1'b0;
      r_err <= 1'b0;
      r_oaddr <= '0;
      r_om <= '0;
      r_on <= '0;
      r_omat <= '0;
    end else begin
      r_state <= w_nstate;
      r_we <= w_fin;
      r_err <= w_start_ok ? 1'b0 : (w_start_bad || w_rej) ? 1'b1 : r_err;
      if (w_start_ok) begin
        r_addr <= bus.dest_addr_in;
        r_m <= bus.m_in;
        r_n <= bus.n_in;
        r_buf <= '{default: '0};
        r_mask <= '0;
        r_cnt <= '0;
      end else if (w_acc) begin
        r_buf <= w_buf;
        r_mask[w_idx] <= 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_fin) begin
        r_oaddr <= r_addr;
        r_om <= r_m;
        r_on <= r_n;
        r_omat <= w_pack;
      end
    end
  end
  assign bus.busy_out = r_state == COLLECTOR_WRITE;
  assign bus.reg_write_en_out = r_we;
  assign bus.done_out = r_we;
  assign bus.error_out = r_err;
  assign bus.reg_write_addr_out = r_oaddr;
  assign bus.reg_write_m_out = r_om;
  assign bus.reg_write_n_out = r_on;
  assign bus.reg_write_matrix_out = r_omat;
endmodule

// File: tb/tb_mpu_collector.sv
// tb_mpu_collector: randomized and directed stimulus against a matrix-level reference model with a write scoreboard
module tb_mpu_collector;
  localparam int FP = 32;
  localparam int M = 3;
  localparam int N = 3;
  localparam int E = M * N;
  typedef struct packed {
    logic [3:0] a;
    logic [2:0] m;
    logic [2:0] n;
    logic [E*FP-1:0] mat;
  } wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mpu_collector_if #(.FP(FP), .M(M), .N(N), .MATRIX_REGISTERS(8)) bus();
  mpu_collector #(.FP(FP), .M(M), .N(N), .MATRIX_REGISTERS(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miss = 0;
  wr_t q[$];
  wr_t held = '0;
  bit act = 0;
  logic [3:0] la;
  logic [2:0] lm, ln;
  logic [FP-1:0] mm [E];
  bit pres [E];
  bit exp_busy = 0, exp_we = 0, exp_err = 0;
  logic [31:0] ft [10];
  task automatic chk(input string nm, input logic [E*FP-1:0] a, input logic [E*FP-1:0] e);
    vectors++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, a, e, $time);
    end
  endtask
  function automatic logic [E*FP-1:0] packed_model();
    logic [E*FP-1:0] p;
    for (int i = 0; i < E; i++) p[(E-1-i)*FP +: FP] = mm[i];
    return p;
  endfunction
  function automatic int filled();
    int f = 0;
    for (int i = 0; i < E; i++) f += int'(pres[i]);
    return f;
  endfunction
  task automatic model(input bit s, input logic [3:0] d, input logic [2:0] m, input logic [2:0] n,
                       input bit v, input logic [31:0] x, input logic [2:0] r, input logic [2:0] c);
    int k;
    wr_t w;
    exp_we = 0;
    if (!act) begin
      if (s) begin
        if (m == 0 || n == 0 || int'(m) > M || int'(n) > N) exp_err = 1;
        else begin
          act = 1; la = d; lm = m; ln = n; exp_err = 0;
          for (int i = 0; i < E; i++) begin mm[i] = '0; pres[i] = 0; end
        end
      end
    end else if (v) begin
      k = int'(r) * N + int'(c);
      if (r >= lm || c >= ln || pres[k]) exp_err = 1;
      else begin
        mm[k] = x;
        pres[k] = 1;
        if (filled() == int'(lm) * int'(ln)) begin
          w.a = la; w.m = lm; w.n = ln; w.mat = packed_model();
          q.push_back(w);
          act = 0;
          exp_we = 1;
        end
      end
    end
    exp_busy = act;
  endtask
  task automatic cyc(input bit s, input logic [3:0] d, input logic [2:0] m, input logic [2:0] n,
                     input bit v, input logic [31:0] x, input logic [2:0] r, input logic [2:0] c);
    @(negedge clk);
    bus.start_in = s; bus.dest_addr_in = d; bus.m_in = m; bus.n_in = n;
    bus.fma_valid_in = v; bus.fma_result_in = x; bus.fma_row_in = r; bus.fma_col_in = c;
    model(s, d, m, n, v, x, r, c);
  endtask
  task automatic idle();
    cyc(0, 4'($urandom), 3'($urandom), 3'($urandom), 0, $urandom, 3'($urandom), 3'($urandom));
  endtask
  task automatic elem(input logic [31:0] x, input int r, input int c);
    cyc(0, 4'($urandom), 3'($urandom), 3'($urandom), 1, x, 3'(r), 3'(c));
  endtask
  task automatic start(input int d, input int m, input int n);
    cyc(1, 4'(d), 3'(m), 3'(n), 0, $urandom, 3'($urandom), 3'($urandom));
  endtask
  task automatic do_reset();
    @(negedge clk);
    bus.start_in = 0; bus.fma_valid_in = 0;
    #2 rst = 1;
    #1;
    chk("rst_busy", bus.busy_out, 0);
    chk("rst_we", bus.reg_write_en_out, 0);
    chk("rst_done", bus.done_out, 0);
    chk("rst_err", bus.error_out, 0);
    chk("rst_addr", bus.reg_write_addr_out, 0);
    chk("rst_m", bus.reg_write_m_out, 0);
    chk("rst_n", bus.reg_write_n_out, 0);
    chk("rst_matrix", bus.reg_write_matrix_out, 0);
    act = 0; exp_busy = 0; exp_we = 0; exp_err = 0;
    q.delete();
    held = '0;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic rnd_run();
    int cells[$];
    int m, n, g, j, t;
    m = $urandom_range(1, 3);
    n = $urandom_range(1, 3);
    if ($urandom_range(0, 5) == 0) start($urandom, $urandom_range(0, 1) ? 0 : $urandom_range(4, 7), n);
    cyc(1, 4'($urandom), 3'(m), 3'(n), 1'($urandom), $urandom, 3'($urandom), 3'($urandom));
    for (int r = 0; r < m; r++) for (int c = 0; c < n; c++) cells.push_back(r * N + c);
    for (int i = cells.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = cells[i]; cells[i] = cells[j]; cells[j] = t;
    end
    while (cells.size() > 0) begin
      g = $urandom_range(0, 9);
      if (g < 2) cyc(g == 1, 4'($urandom), 3'($urandom_range(1, 3)), 3'($urandom_range(1, 3)), 0, $urandom, 0, 0);
      else if (g == 2) elem($urandom, $urandom_range(0, 7), $urandom_range(0, 7));
      else begin
        t = cells.pop_front();
        elem($urandom, t / N, t % N);
      end
    end
    if ($urandom_range(0, 1) == 1) idle();
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        chk("busy", bus.busy_out, exp_busy);
        chk("write_en", bus.reg_write_en_out, exp_we);
        chk("done", bus.done_out, exp_we);
        chk("error", bus.error_out, exp_err);
        if (bus.reg_write_en_out) begin
          if (q.size() == 0) begin
            vectors++; miss++;
            $display("FAIL unexpected_write actual=1 expected=0 at %0t", $time);
          end else held = q.pop_front();
        end
        chk("wr_addr", bus.reg_write_addr_out, held.a);
        chk("wr_m", bus.reg_write_m_out, held.m);
        chk("wr_n", bus.reg_write_n_out, held.n);
        chk("wr_matrix", bus.reg_write_matrix_out, held.mat);
      end
    end
  end
  initial begin
    ft = '{32'h0, 32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
           32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000, 32'h41100000};
    bus.start_in = 0; bus.dest_addr_in = 0; bus.m_in = 0; bus.n_in = 0;
    bus.fma_valid_in = 0; bus.fma_result_in = 0; bus.fma_row_in = 0; bus.fma_col_in = 0;
    do_reset();
    elem(32'h12345678, 0, 0);
    start(5, 3, 3);
    for (int i = 0; i < 9; i++) elem(ft[i+1], i / 3, i % 3);
    idle(); idle();
    start(2, 2, 2);
    elem(ft[4], 1, 1); idle();
    elem(ft[1], 0, 0); idle(); idle();
    elem(ft[3], 1, 0); idle();
    elem(ft[2], 0, 1);
    idle(); idle();
    start(1, 3, 3);
    elem(ft[1], 0, 0);
    elem(ft[7], 0, 0);
    elem(ft[8], 2, 3);
    for (int i = 1; i < 9; i++) elem(ft[i+1], i / 3, i % 3);
    start(3, 3, 3);
    for (int i = 0; i < 4; i++) elem(ft[9-i], i / 3, i % 3);
    do_reset();
    start(3, 3, 3);
    for (int i = 8; i >= 0; i--) elem(ft[i+1] ^ 32'h00400000, i / 3, i % 3);
    idle();
    start(4, 0, 3); idle();
    start(4, 4, 2); idle();
    start(4, 2, 0); idle();
    start(6, 3, 3);
    elem(ft[5], 1, 1);
    cyc(1, 7, 1, 1, 1, ft[6], 1, 2);
    for (int i = 0; i < 9; i++) if (i != 4 && i != 5) elem(ft[i+1], i / 3, i % 3);
    for (int k = 0; k < 40; k++) begin
      rnd_run();
      if (k == 20) begin
        start(9, 3, 2);
        elem($urandom, 0, 1);
        elem($urandom, 2, 0);
        do_reset();
      end
    end
    repeat (3) idle();
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule

// File: doc/mpu_collector.md
# mpu_collector

Result collector for the MPU multiply path. Sits directly downstream of the FMA array: accepts one finished `float_sp` element per handshake, tagged with its row/column, assembles them into an M×N matrix buffer and, once every element of the active result is present, issues a single whole-matrix write to the matrix register file at the destination address. Runs on the `collector_state_e` state set from `mpu_data_types`.

## Interface
Parameters:
- `FP`, 32, floating-point width; element type is `float_sp`.
- `M`, 3, maximum rows.
- `N`, 3, maximum columns.
- `MATRIX_REGISTERS`, 8, register file depth; address width `MATRIX_REG_BITS+1`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_in`  in  1  one-cycle request to begin collecting a result.
- `dest_addr_in`  in  MATRIX_REG_BITS+1  destination register, latched on start.
- `m_in`  in  MBITS+1  result rows, latched on start.
- `n_in`  in  NBITS+1  result columns, latched on start.
- `fma_valid_in`  in  1  element present on `fma_result_in`.
- `fma_result_in`  in  FP  finished element (`float_sp`).
- `fma_row_in`  in  MBITS+1  element row.
- `fma_col_in`  in  NBITS+1  element column.
- `busy_out`  out  1  high while in COLLECTOR_WRITE.
- `reg_write_en_out`  out  1  one-cycle register-file write strobe.
- `reg_write_addr_out`  out  MATRIX_REG_BITS+1  write address.
- `reg_write_m_out`, `reg_write_n_out`  out  MBITS+1 / NBITS+1  result dimensions.
- `reg_write_matrix_out`  out  M*N*FP  packed `float_sp [0:M*N-1]`, element (r,c) at index r*N+c, index 0 in the MSBs.
- `done_out`  out  1  one-cycle completion pulse, coincident with the write strobe.
- `error_out`  out  1  sticky protocol error; cleared by the next accepted start.

## Operation
- States: COLLECTOR_IDLE, COLLECTOR_WRITE.
- IDLE + `start_in`:
  - If `m_in`==0, `n_in`==0, `m_in`>M or `n_in`>N: set `error_out` and stay IDLE.
  - Otherwise: latch address and dimensions, clear the buffer to 0, clear the presence mask and element count, clear `error_out`, go to WRITE.
- `fma_valid_in` in IDLE, or in the cycle `start_in` is sampled, is ignored (no store, no error).
- WRITE + `fma_valid_in`:
  - If row ≥ latched m, col ≥ latched n, or the presence bit is already set: drop the element, set `error_out`, count unchanged.
  - Otherwise: store the element at buffer[row][col], set the presence bit, count += 1. Count is `$clog2(M*N+1)` bits.
- When an accepted element makes count == m*n:
  - On that edge, go to IDLE.
  - Register `reg_write_en_out`=1 and `done_out`=1 for exactly one cycle, with address, dimensions and the full buffer on the write outputs.
  - Slots outside m×n read as 0.
- `start_in` while in WRITE is ignored; latched parameters are unchanged.
- Write-side outputs (`reg_write_addr_out`, `reg_write_m_out`, `reg_write_n_out`, `reg_write_matrix_out`) hold their values after the strobe until the next completion.
- No backpressure: the FMA array may present one element every cycle.

## Timing
- Reset: state IDLE, buffer/mask/count 0; every output 0. Takes effect immediately, mid-operation included; a partial matrix is discarded and no write is issued.
- Start to `busy_out` high: 1 cycle (registered).
- Final accepted element to write strobe/`done_out`: 1 cycle. `busy_out` falls in the same cycle the strobe rises.
- A new `start_in` is accepted in the cycle the strobe is high (state is already IDLE).
- Minimum full 3×3 turnaround: 1 (start) + 9 (elements) + 1 (write) = 11 cycles.
- `error_out` rises 1 cycle after the offending start/element.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> all outputs 0 immediately; `busy_out`=0.
- 3×3 raster: start with dest=5, m=3, n=3; feed 1.0..9.0 back-to-back in raster order -> one cycle after the 9th element, `reg_write_en_out`=1, addr=5, index0=32'h3f800000, index8=32'h41100000; `done_out` pulse is exactly 1 cycle; `busy_out`=0.
- 2×2 out of order with gaps: start with dest=2, m=2, n=2; feed (1,1)=4.0, (0,0)=1.0, (1,0)=3.0, (0,1)=2.0 with idle cycles between -> write after the 4th element; indices 0,1,3,4 = 1.0,2.0,3.0,4.0; indices 2,5,6,7,8 = 0.
- Duplicate/out of range: 3×3 run; send (0,0) twice, then (2,3) -> `error_out`=1 one cycle after the duplicate, count unchanged; no write until all 9 distinct elements arrive; the first (0,0) value is retained.
- Reset mid-collection: after 4 of 9 elements, pulse `rst` -> no write strobe; a following start with 9 elements completes normally with the buffer containing only the new data.
- Illegal/ignored starts: start with m=0 -> `error_out`=1, `busy_out`=0. A second `start_in` with dest=7 during an active run -> ignored; the write goes to the originally latched address.
